// File: rtl/dec8_conv_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dec8_arb_pkg
// Purpose  : Shared types and constants for the dec8_conv_arbiter slice.
//            Defines the FSM state encoding, the operand and result widths,
//            the largest operand that fits in 8 BCD digits, and the result
//            code returned for an out-of-range operand.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dec8_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam int              BIN_W    = 27;
  localparam int              DEC_W    = 32;
  localparam logic [BIN_W-1:0] DEC_MAX  = 27'd99_999_999;
  localparam logic [DEC_W-1:0] OVF_CODE = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/dec8_conv_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dec8_conv_arbiter_if
// Purpose  : Bundles the requester side and the converter side of the
//            shared binary-to-BCD converter arbiter.
// Ports    : req/bin_in/conv_ddec driven by the master (clients+converter);
//            gnt/done/dec_out/busy/conv_bin/conv_st driven by the slave
//            (the arbiter). With DEC8_ARB_OVF_EN defined an extra ovf flag
//            is driven by the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface dec8_conv_arbiter_if
  import dec8_arb_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  logic [N_REQ-1:0]       req;
  logic [BIN_W*N_REQ-1:0] bin_in;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic [DEC_W-1:0]       dec_out;
  logic                   busy;
  logic [BIN_W-1:0]       conv_bin;
  logic                   conv_st;
  logic [DEC_W-1:0]       conv_ddec;
`ifdef DEC8_ARB_OVF_EN
  logic                   ovf;

  modport master (
    output req, bin_in, conv_ddec,
    input  gnt, done, dec_out, busy, conv_bin, conv_st, ovf
  );

  modport slave (
    input  req, bin_in, conv_ddec,
    output gnt, done, dec_out, busy, conv_bin, conv_st, ovf
  );
`else
  modport master (
    output req, bin_in, conv_ddec,
    input  gnt, done, dec_out, busy, conv_bin, conv_st
  );

  modport slave (
    input  req, bin_in, conv_ddec,
    output gnt, done, dec_out, busy, conv_bin, conv_st
  );
`endif

endinterface
`default_nettype wire

// File: rtl/dec8_conv_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Scans req starting one past
//            rr_ptr, wrapping modulo N_REQ, and reports the first set bit.
// Ports    : req    - request vector
//            rr_ptr - index of the most recently served requester
//            onehot - one-hot of the winner (0 when none)
//            index  - binary index of the winner
//            valid  - at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [N_REQ-1:0]         onehot,
  output logic [$clog2(N_REQ)-1:0] index,
  output logic                     valid
);

  localparam int IDX_W = $clog2(N_REQ);

  int               w_pos;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    onehot = '0;
    index  = '0;
    valid  = 1'b0;
    w_pos  = 0;
    w_cand = '0;
    // Offset 1 first so the last winner has lowest priority; offset N_REQ
    // lands back on rr_ptr itself.
    for (int off = 1; off <= N_REQ; off++) begin
      w_pos  = (int'(rr_ptr) + off) % N_REQ;
      w_cand = IDX_W'(w_pos);
      if (!valid && req[w_cand]) begin
        valid          = 1'b1;
        index          = w_cand;
        onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dec8_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dec8_conv_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one HEX27_to_DEC8
//            converter among N_REQ requesters. Grants one requester, latches
//            its operand, pulses conv_st, waits CONV_CYCLES clocks, captures
//            the BCD result and strobes done to the granted requester.
// Ports    : clk, rst (async, active high)
//            bus (slave modport): req, bin_in, conv_ddec in;
//            gnt, done, dec_out, busy, conv_bin, conv_st out.
// Options  : DEC8_ARB_OVF_EN - operands above 99_999_999 bypass the
//            converter, return OVF_CODE and raise ovf with done.
// Revision : 1.0 - initial release
// ============================================================================
module dec8_conv_arbiter
  import dec8_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int CONV_CYCLES = 30
) (
  input  logic               clk,
  input  logic               rst,
  dec8_conv_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(CONV_CYCLES);

  localparam logic [IDX_W-1:0] c_ptr_init = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(CONV_CYCLES - 1);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_idx;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic [DEC_W-1:0] r_dec_out;
  logic [BIN_W-1:0] r_conv_bin;
  logic             r_conv_st;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
`ifdef DEC8_ARB_OVF_EN
  logic             r_ovf;
`endif

  logic [N_REQ-1:0] w_onehot;
  logic [IDX_W-1:0] w_idx;
  logic             w_valid;
  logic [BIN_W-1:0] w_sel_bin;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req    (bus.req),
    .rr_ptr (r_rr_ptr),
    .onehot (w_onehot),
    .index  (w_idx),
    .valid  (w_valid)
  );

  assign w_sel_bin = bus.bin_in[int'(w_idx)*BIN_W +: BIN_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= c_ptr_init;
      r_idx      <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_dec_out  <= '0;
      r_conv_bin <= '0;
      r_conv_st  <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
`ifdef DEC8_ARB_OVF_EN
      r_ovf      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_gnt  <= w_onehot;
            r_idx  <= w_idx;
            r_busy <= 1'b1;
`ifdef DEC8_ARB_OVF_EN
            if (w_sel_bin > DEC_MAX) begin
              // Cannot be shown in 8 digits: answer directly, skip converter.
              r_dec_out <= OVF_CODE;
              r_ovf     <= 1'b1;
              r_done    <= w_onehot;
              r_state   <= DONE;
            end else begin
              r_conv_bin <= w_sel_bin;
              r_conv_st  <= 1'b1;
              r_cnt      <= c_cnt_load;
              r_state    <= WAIT;
            end
`else
            r_conv_bin <= w_sel_bin;
            r_conv_st  <= 1'b1;
            r_cnt      <= c_cnt_load;
            r_state    <= WAIT;
`endif
          end
        end

        WAIT: begin
          r_conv_st <= 1'b0;
          if (r_cnt == '0) begin
            // CONV_CYCLES edges after the grant edge: converter output valid.
            r_dec_out <= bus.conv_ddec;
            r_done    <= r_gnt;
`ifdef DEC8_ARB_OVF_EN
            r_ovf     <= 1'b0;
`endif
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        DONE: begin
          r_done   <= '0;
          r_gnt    <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= r_idx;
          r_state  <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.done     = r_done;
  assign bus.dec_out  = r_dec_out;
  assign bus.busy     = r_busy;
  assign bus.conv_bin = r_conv_bin;
  assign bus.conv_st  = r_conv_st;
`ifdef DEC8_ARB_OVF_EN
  assign bus.ovf      = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dec8_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec8_conv_arbiter
// Purpose  : Self-checking bench for dec8_conv_arbiter with a behavioural
//            HEX27_to_DEC8 model whose result becomes valid CONV_CYCLES
//            clocks after conv_st. Covers DEC8_ARB_OVF_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dec8_conv_arbiter;
  import dec8_arb_pkg::*;

  localparam int N_REQ       = 4;
  localparam int CONV_CYCLES = 30;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dec8_conv_arbiter_if #(.N_REQ(N_REQ)) bus ();

  dec8_conv_arbiter #(
    .N_REQ       (N_REQ),
    .CONV_CYCLES (CONV_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- behavioural converter ----------------
  function automatic logic [31:0] to_bcd(input logic [26:0] v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = int'(v);
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  logic [26:0] m_val;
  int          m_cnt = 0;
  logic [31:0] m_ddec = 32'h0;
  assign bus.conv_ddec = m_ddec;

  // Result is garbage until the edge before the arbiter should sample it.
  always @(posedge clk) begin
    if (bus.conv_st) begin
      m_val  <= bus.conv_bin;
      m_ddec <= 32'hAAAA_AAAA;
      m_cnt  <= CONV_CYCLES - 2;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_ddec <= to_bcd(m_val);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [107:0] mk(input logic [26:0] b3, input logic [26:0] b2,
                                      input logic [26:0] b1, input logic [26:0] b0);
    return {b3, b2, b1, b0};
  endfunction

  // Waits (bounded) for a grant; returns edges waited.
  task automatic wait_grant(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (bus.gnt == '0 && n < 100);
  endtask

  task automatic expect_txn(input string tag, input int idx, input logic [31:0] exp_dec,
                            input bit drop);
    int          n;
    logic [3:0]  oh;
    oh = 4'b0001 << idx;
    wait_grant(n);
    chk({tag, "_gnt"}, 64'(bus.gnt), 64'(oh));
    chk({tag, "_st"}, 64'(bus.conv_st), 64'd1);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    chk({tag, "_st_low"}, 64'(bus.conv_st), 64'd0);
    n = 1;
    while (bus.done == '0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(CONV_CYCLES));
    chk({tag, "_done"}, 64'(bus.done), 64'(oh));
    chk({tag, "_dec"}, 64'(bus.dec_out), 64'(exp_dec));
    chk({tag, "_gnt_hold"}, 64'(bus.gnt), 64'(oh));
`ifdef DEC8_ARB_OVF_EN
    chk({tag, "_ovf"}, 64'(bus.ovf), 64'd0);
`endif
    if (drop) bus.req[idx] = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_end"}, 64'(bus.done), 64'd0);
    chk({tag, "_gnt_end"}, 64'(bus.gnt), 64'd0);
    chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
  endtask

  typedef struct {
    string        tag;
    logic [3:0]   req_or;
    logic [107:0] bin;
    int           idx;
    logic [31:0]  dec;
    bit           drop;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int e;

    rst        = 1'b1;
    bus.req    = '0;
    bus.bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dec", 64'(bus.dec_out), 64'd0);
    chk("rst_conv_bin", 64'(bus.conv_bin), 64'd0);
    chk("rst_conv_st", 64'(bus.conv_st), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // All four at once (rr_ptr starts at 3 -> 0,1,2,3), single request,
    // then req[0] held permanently alongside req[2] (alternation).
    vecs[0]  = '{"all0", 4'b1111, mk(27'd5, 27'd99_999_999, 27'd12_345_678, 27'd0), 0, 32'h0000_0000, 1'b1};
    vecs[1]  = '{"all1", 4'b0000, mk(27'd5, 27'd99_999_999, 27'd12_345_678, 27'd0), 1, 32'h1234_5678, 1'b1};
    vecs[2]  = '{"all2", 4'b0000, mk(27'd5, 27'd99_999_999, 27'd12_345_678, 27'd0), 2, 32'h9999_9999, 1'b1};
    vecs[3]  = '{"all3", 4'b0000, mk(27'd5, 27'd99_999_999, 27'd12_345_678, 27'd0), 3, 32'h0000_0005, 1'b1};
    vecs[4]  = '{"single", 4'b0001, mk(27'd0, 27'd0, 27'd0, 27'h16A9D55), 0, 32'h2376_4309, 1'b1};
    vecs[5]  = '{"fair_a", 4'b0101, mk(27'd0, 27'd2024, 27'd0, 27'd7), 2, 32'h0000_2024, 1'b1};
    vecs[6]  = '{"fair_b", 4'b0100, mk(27'd0, 27'd2024, 27'd0, 27'd7), 0, 32'h0000_0007, 1'b0};
    vecs[7]  = '{"fair_c", 4'b0000, mk(27'd0, 27'd2024, 27'd0, 27'd7), 2, 32'h0000_2024, 1'b1};
    vecs[8]  = '{"fair_d", 4'b0100, mk(27'd0, 27'd2024, 27'd0, 27'd7), 0, 32'h0000_0007, 1'b0};
    vecs[9]  = '{"fair_e", 4'b0000, mk(27'd0, 27'd2024, 27'd0, 27'd7), 2, 32'h0000_2024, 1'b1};
    vecs[10] = '{"fair_f", 4'b0000, mk(27'd0, 27'd2024, 27'd0, 27'd7), 0, 32'h0000_0007, 1'b1};

    for (int i = 0; i < 11; i++) begin
      bus.req    = bus.req | vecs[i].req_or;
      bus.bin_in = vecs[i].bin;
      expect_txn(vecs[i].tag, vecs[i].idx, vecs[i].dec, vecs[i].drop);
    end

    // req[1] dropped mid-WAIT and its operand changed after the grant.
    bus.bin_in = mk(27'd0, 27'd0, 27'd1234, 27'd0);
    bus.req    = 4'b0010;
    wait_grant(n);
    chk("drop_gnt", 64'(bus.gnt), 64'b0010);
    chk("drop_conv_bin", 64'(bus.conv_bin), 64'd1234);
    e = 0;
    repeat (3) @(posedge clk);
    e += 3;
    bus.bin_in = mk(27'd0, 27'd0, 27'd777, 27'd0);
    repeat (7) @(posedge clk);
    e += 7;
    #1;
    bus.req[1] = 1'b0;
    while (bus.done == '0 && e < 200) begin
      @(posedge clk); #1; e++;
    end
    chk("drop_lat", 64'(e), 64'(CONV_CYCLES));
    chk("drop_done", 64'(bus.done), 64'b0010);
    chk("drop_dec", 64'(bus.dec_out), 64'h1234);
    @(posedge clk); #1;
    chk("drop_gnt_end", 64'(bus.gnt), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("drop_no_regrant", 64'(bus.gnt), 64'd0);
    chk("drop_idle_busy", 64'(bus.busy), 64'd0);

    // Reset during WAIT: immediate clear, then requester 0 wins first.
    bus.bin_in = mk(27'd0, 27'd55, 27'd0, 27'd9);
    bus.req    = 4'b0100;
    wait_grant(n);
    chk("rw_gnt", 64'(bus.gnt), 64'b0100);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rw_gnt_clr", 64'(bus.gnt), 64'd0);
    chk("rw_busy_clr", 64'(bus.busy), 64'd0);
    chk("rw_dec_clr", 64'(bus.dec_out), 64'd0);
    chk("rw_bin_clr", 64'(bus.conv_bin), 64'd0);
    chk("rw_done_clr", 64'(bus.done), 64'd0);
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    bus.req = 4'b0101;
    expect_txn("rw_r0", 0, 32'h0000_0009, 1'b1);
    expect_txn("rw_r2", 2, 32'h0000_0055, 1'b1);

`ifdef DEC8_ARB_OVF_EN
    // Out-of-range operand: answered in one cycle without the converter.
    bus.bin_in = mk(27'd0, 27'd0, 27'd0, 27'd100_000_000);
    bus.req    = 4'b0001;
    wait_grant(n);
    chk("ovf_gnt", 64'(bus.gnt), 64'b0001);
    chk("ovf_done", 64'(bus.done), 64'b0001);
    chk("ovf_st", 64'(bus.conv_st), 64'd0);
    chk("ovf_flag", 64'(bus.ovf), 64'd1);
    chk("ovf_dec", 64'(bus.dec_out), 64'hFFFF_FFFF);
    chk("ovf_busy", 64'(bus.busy), 64'd1);
    bus.req[0] = 1'b0;
    @(posedge clk); #1;
    chk("ovf_done_end", 64'(bus.done), 64'd0);
    chk("ovf_gnt_end", 64'(bus.gnt), 64'd0);
    bus.bin_in = mk(27'd0, 27'd0, 27'd0, 27'd42);
    bus.req    = 4'b0001;
    expect_txn("ovf_next", 0, 32'h0000_0042, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dec8_conv_arbiter.md
Name: dec8_conv_arbiter

Overview:
Round-robin arbiter and sequencer that shares one HEX27_to_DEC8 binary-to-BCD converter between N_REQ requesters.
- Grants one requester at a time and latches its 27-bit operand onto the converter.
- Pulses the converter start, waits a fixed conversion time, then captures the 8-digit BCD result.
- Returns the result with a one-cycle done strobe to the granted requester.
- Sits between display/UART clients and the single converter instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
CONV_CYCLES, 30, clocks from conv_st rising to conv_ddec valid (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req  in  N_REQ  per-requester request level, held until own done
bin_in  in  27*N_REQ  flattened operands, slice i = bin_in[27*i+26:27*i]
gnt  out  N_REQ  one-hot grant, high from grant edge until done cycle ends
done  out  N_REQ  one-cycle strobe to granted requester, dec_out valid
dec_out  out  32  captured BCD result (8 digits), held until next capture
busy  out  1  high in WAIT and DONE
conv_bin  out  27  operand driven to converter Dbin
conv_st  out  1  converter start pulse, exactly one cycle
conv_ddec  in  32  converter Ddec

Behaviour:
- States: IDLE, WAIT, DONE. Outputs are registered.
- Reset (async, any state): state=IDLE; gnt, done, dec_out, conv_bin, conv_st, busy = 0; cnt=0; rr_ptr=N_REQ-1.
- IDLE, req!=0 at edge k:
  - Pick the first set req scanning from rr_ptr+1, wrapping modulo N_REQ.
  - gnt<=onehot(i); conv_bin<=slice i; conv_st<=1; cnt<=CONV_CYCLES-1; state<=WAIT.
- IDLE, req==0: no change.
- WAIT:
  - conv_st<=0 at the first WAIT edge.
  - cnt decrements each edge.
  - At the edge where cnt==0: dec_out<=conv_ddec, done<=gnt, state<=DONE.
- DONE (exactly one cycle):
  - done and gnt high; req is not sampled.
  - At the next edge: done<=0, gnt<=0, rr_ptr<=i, state<=IDLE.
- Latency: grant at edge k, done high in the cycle after edge k+CONV_CYCLES; the next grant is no earlier than edge k+CONV_CYCLES+2.
- Requester rule: deassert req on the edge ending the done cycle. A req still high in IDLE is a new request.
- req dropped during WAIT is ignored. The conversion completes and done still pulses.
- bin_in changes after grant have no effect, because conv_bin is latched.
- Simultaneous requests: the round-robin winner is served. Losers keep req and are served in later rounds. There is no starvation: each requester waits at most N_REQ-1 conversions.
- Reset during WAIT: conversion is abandoned, no done, the converter is left to free-run.
- Converter ptr_dig is not used.

Optional Feature:
Macro DEC8_ARB_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), reset 0.
  - In IDLE, if the selected operand > 27'd99_999_999: no conv_st; dec_out<=32'hFFFF_FFFF; ovf<=1; done<=onehot(i), gnt<=onehot(i); state<=DONE directly; rr_ptr updates as normal.
  - ovf is valid with done and held until the next capture; 0 for in-range operands.
- Undefined:
  - No ovf port. All operands are converted and conv_ddec is passed through unchanged.

Decomposition:
- Package dec8_arb_pkg: state enum {IDLE, WAIT, DONE}; BIN_W=27; DEC_W=32; DEC_MAX=27'd99_999_999; OVF_CODE=32'hFFFF_FFFF.
- Sub-module rr_pick: combinational round-robin picker. Inputs req and rr_ptr; outputs onehot, index and valid.
- Bench uses the real HEX27_to_DEC8, or a behavioural model honouring CONV_CYCLES.

Test Plan:
- Single request: req=4'b0001, bin_in[0]=27'h16A9D55 -> conv_st one cycle, done[0] after CONV_CYCLES+1 edges, dec_out=32'h23764309.
- All four requesting at once, operands 0, 12345678, 99999999, 5 -> grants in order 0,1,2,3; dec_out 32'h0, 32'h12345678, 32'h99999999, 32'h5; exactly one done per requester.
- Fairness: req[0] held permanently high plus req[2] -> grants alternate 0,2,0,2; req[2] waits at most one conversion.
- req[1] dropped mid-WAIT -> done[1] still pulses; no new grant until the DONE state has ended.
- rst asserted in WAIT -> outputs 0 immediately (async), no done; after release, a new req is served with rr_ptr=N_REQ-1 (requester 0 first).
- DEC8_ARB_OVF_EN: bin_in=27'd100_000_000 -> no conv_st, done one cycle after grant edge, ovf=1, dec_out=32'hFFFF_FFFF; next in-range request gives ovf=0.
